// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer read arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: default frame geometry, RGB565 pixel type, read-tag struct, one-hot helper.
package fb_arb_pkg;

    localparam int IMG_WIDTH_DEF  = 160;
    localparam int IMG_HEIGHT_DEF = 120;
    localparam int PIXELS         = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;

    // Requester id width covers the largest supported requester count (8).
    localparam int ID_W = 3;

    typedef logic [15:0] rgb565_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    function automatic logic [7:0] id_to_onehot(input logic [ID_W-1:0] id);
        return 8'd1 << id;
    endfunction

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Bundles the requester side and frame-buffer side signals of fb_read_arbiter.
// Latency: n/a (wiring only). Backpressure: requesters hold req until gnt.
// Optional FB_ARB_STATS_EN adds stall_cnt / grant_cnt statistics outputs.
interface fb_read_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 15
);
    import fb_arb_pkg::*;

    logic                          arb_en;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fb_re;
    logic [ADDR_WIDTH-1:0]         fb_addr;
    rgb565_t                       fb_rdata;
    logic [NUM_REQ-1:0]            rvalid;
    rgb565_t                       rdata;
    logic                          busy;
    logic                          addr_err;
`ifdef FB_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]         stall_cnt;
    logic [31:0]                   grant_cnt;
`endif

    // master: requesters + frame-buffer model; slave: the arbiter.
    modport master (
        output arb_en, req, req_addr, fb_rdata,
        input  gnt, fb_re, fb_addr, rvalid, rdata, busy, addr_err
`ifdef FB_ARB_STATS_EN
        , input stall_cnt, grant_cnt
`endif
    );

    modport slave (
        input  arb_en, req, req_addr, fb_rdata,
        output gnt, fb_re, fb_addr, rvalid, rdata, busy, addr_err
`ifdef FB_ARB_STATS_EN
        , output stall_cnt, grant_cnt
`endif
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: lowest index at or above ptr, wrapping.
// Latency: 0 cycles. Backpressure: none; losers simply see gnt=0.
// Ports: req (requests), ptr (priority start), gnt (one-hot), gnt_id, gnt_vld.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_id,
    output logic               gnt_vld
);

    logic [PTR_W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest requester at or
    // above ptr overwrites any earlier candidate.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_read_arbiter.sv
// Round-robin arbiter sharing one frame-buffer read port among NUM_REQ requesters.
// Latency: gnt same cycle, fb_re/fb_addr +1, rvalid/rdata +2+RD_LATENCY; one grant per cycle.
// Backpressure: req held until gnt; arb_en=0 blocks new grants while in-flight reads drain.
// Ports: clk, reset (async, active-low), bus (fb_read_arbiter_if.slave).
// Optional macro FB_ARB_STATS_EN adds per-requester stall counters and a grant counter.
module fb_read_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    fb_read_arbiter_if.slave   bus
);

    localparam int PIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int NSTG  = RD_LATENCY + 1;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  fb_re_q, fb_re_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
    rgb565_t               rdata_q, rdata_d;
    logic                  addr_err_q, addr_err_d;
    rd_tag_t               tag_q [NSTG];
    rd_tag_t               tag_d [NSTG];

    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    win_gnt;
    logic [PTR_W-1:0]      win_id;
    logic                  win_vld;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  addr_bad;
    logic                  tag_any;

    // Reset is folded in so gnt is low while reset is asserted.
    assign arb_req = bus.req & {NUM_REQ{bus.arb_en & reset}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (arb_req),
        .ptr     (rr_ptr_q),
        .gnt     (win_gnt),
        .gnt_id  (win_id),
        .gnt_vld (win_vld)
    );

    assign bus.gnt  = win_gnt;
    assign sel_addr = bus.req_addr[int'(win_id) * ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_bad = win_vld && (32'(sel_addr) >= 32'(PIX));

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        fb_re_d    = win_vld;
        fb_addr_d  = fb_addr_q;
        addr_err_d = addr_err_q | addr_bad;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        tag_any    = 1'b0;

        if (win_vld) begin
            rr_ptr_d  = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
            // Out-of-range pixel addresses read pixel 0 instead of wrapping.
            fb_addr_d = addr_bad ? '0 : sel_addr;
        end

        // Tag stage s lines up with the frame buffer s cycles after fb_re;
        // the last stage coincides with valid fb_rdata.
        tag_d[0] = '{valid: win_vld, id: ID_W'(win_id)};
        for (int s = 1; s < NSTG; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        for (int s = 0; s < NSTG; s++) begin
            tag_any = tag_any | tag_q[s].valid;
        end

        if (tag_q[NSTG-1].valid) begin
            rvalid_d = NUM_REQ'(id_to_onehot(tag_q[NSTG-1].id));
            rdata_d  = bus.fb_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            fb_re_q    <= 1'b0;
            fb_addr_q  <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
            for (int s = 0; s < NSTG; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            fb_re_q    <= fb_re_d;
            fb_addr_q  <= fb_addr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
            for (int s = 0; s < NSTG; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign bus.fb_re    = fb_re_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = fb_re_q | tag_any;

`ifdef FB_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]              grant_cnt_q, grant_cnt_d;

    // Stall counts raw req, so cycles blocked by arb_en=0 also count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        grant_cnt_d = grant_cnt_q + {31'd0, win_vld};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && !win_gnt[i] && stall_cnt_q[i] != 16'hFFFF) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.grant_cnt = grant_cnt_q;
`endif

endmodule
